// File: rtl/usb_pkg.sv
// Shared FT245 link definitions for usb_output and usb_input: FSM state encoding and bus timing defaults.
package usb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE  = 3'd2,
    HOLD    = 3'd3,
    RECOVER = 3'd4
  } usb_state_e;

  localparam int FT_DATA_W         = 8;
  localparam int FT_DEPTH          = 16;
  localparam int FT_WR_CYCLES      = 2;
  localparam int FT_RECOVER_CYCLES = 4;
  localparam int FT_CNT_W          = 8;

endpackage

// File: rtl/usb_output_byte_fifo.sv
// Synchronous byte FIFO with first-word fall-through; pointers carry one extra wrap bit.
module byte_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_b,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;
  assign dout      = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/usb_output.sv
// FT245 transmit side: byte FIFO, TXE# synchroniser and WR strobe sequencer.
// Define USB_OUTPUT_DEBUG_EN to add the state and sent_count debug ports.
module usb_output
  import usb_pkg::*;
#(
  parameter int DEPTH          = FT_DEPTH,
  parameter int WR_CYCLES      = FT_WR_CYCLES,
  parameter int RECOVER_CYCLES = FT_RECOVER_CYCLES
) (
  input  logic        clock,
  input  logic        reset_b,
  input  logic [7:0]  in,
  input  logic        newin,
  input  logic        hold,
  input  logic        rx_busy,
  output logic        full,
  output logic        empty,
  output logic        overflow,
  input  logic        txe_b,
  output logic        wr,
  output logic [7:0]  data_out,
  output logic        data_oe
`ifdef USB_OUTPUT_DEBUG_EN
  ,
  output logic [3:0]  state,
  output logic [15:0] sent_count
`endif
);

  localparam logic [FT_CNT_W-1:0] WR_LAST  = FT_CNT_W'(WR_CYCLES - 1);
  localparam logic [FT_CNT_W-1:0] REC_LAST = FT_CNT_W'(RECOVER_CYCLES - 1);
  localparam logic [FT_CNT_W-1:0] CNT_ONE  = FT_CNT_W'(1);

  usb_state_e          r_state;
  usb_state_e          w_state_next;
  logic [FT_CNT_W-1:0] r_cnt;
  logic                r_txe_s1;
  logic                r_txe_s2;
  logic                r_overflow;
  logic [7:0]          r_data_out;
  logic [7:0]          w_fifo_dout;
  logic                w_full;
  logic                w_empty;
  logic                w_txe_ok;
  logic                w_ready;
  logic                w_launch;

  byte_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FT_DATA_W)
  ) u_fifo (
    .clock   (clock),
    .reset_b (reset_b),
    .push    (newin),
    .pop     (w_launch),
    .din     (in),
    .dout    (w_fifo_dout),
    .full    (w_full),
    .empty   (w_empty)
  );

  // Synchroniser resets to "not ready" so nothing launches before TXE# is really seen low.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      r_txe_s1 <= 1'b1;
      r_txe_s2 <= 1'b1;
    end else begin
      r_txe_s1 <= txe_b;
      r_txe_s2 <= r_txe_s1;
    end
  end

  assign w_txe_ok = ~r_txe_s2;
  assign w_ready  = ~w_empty & w_txe_ok & ~hold & ~rx_busy;

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= (w_state_next != r_state) ? '0 : r_cnt + CNT_ONE;
    end
  end

  // The last RECOVER clock doubles as the launch decision so back-to-back bytes take 1+WR+1+RECOVER clocks.
  always_comb begin
    w_state_next = r_state;
    w_launch     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_ready) begin
          w_launch     = 1'b1;
          w_state_next = SETUP;
        end
      end
      SETUP:  w_state_next = STROBE;
      STROBE: if (r_cnt == WR_LAST) w_state_next = HOLD;
      HOLD:   w_state_next = RECOVER;
      RECOVER: begin
        if (r_cnt == REC_LAST) begin
          if (w_ready) begin
            w_launch     = 1'b1;
            w_state_next = SETUP;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      r_data_out <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_launch)       r_data_out <= w_fifo_dout;
      if (newin & w_full) r_overflow <= 1'b1;
    end
  end

  assign wr       = (r_state == STROBE);
  assign data_oe  = (r_state == SETUP) || (r_state == STROBE) || (r_state == HOLD);
  assign data_out = r_data_out;
  assign full     = w_full;
  assign empty    = w_empty;
  assign overflow = r_overflow;

`ifdef USB_OUTPUT_DEBUG_EN
  logic [15:0] r_sent_count;

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      r_sent_count <= '0;
    end else if (r_state == STROBE && w_state_next == HOLD) begin
      r_sent_count <= r_sent_count + 16'd1;
    end
  end

  assign state      = {1'b0, r_state};
  assign sent_count = r_sent_count;
`endif

endmodule

// File: tb/tb_usb_output.sv
// Scoreboard bench for usb_output: bytes queued on push, checked as each write appears on the bus.
// Debug-port checks are compiled in when USB_OUTPUT_DEBUG_EN is defined.
`timescale 1ns/1ps
module tb_usb_output;

  localparam int DEPTH       = 16;
  localparam int WR_CYC      = 2;
  localparam int BYTE_PERIOD = 8;

  logic       clock = 1'b0;
  logic       reset_b = 1'b0;
  logic [7:0] in_byte = 8'h00;
  logic       newin = 1'b0;
  logic       hold = 1'b0;
  logic       rx_busy = 1'b0;
  logic       txe_b = 1'b1;
  logic       full, empty, overflow, wr, data_oe;
  logic [7:0] data_out;
`ifdef USB_OUTPUT_DEBUG_EN
  logic [3:0]  state;
  logic [15:0] sent_count;
`endif

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  logic [7:0] expQ[$];
  logic [7:0] curByte = 8'h00;
  bit   abortFlag = 1'b0;
  bit   spacingOn = 1'b0;
  bit   haveLastRise = 1'b0;
  int   oeRiseCycle = 0, wrFallCycle = 0, lastRise = 0, wrHigh = 0, wrRises = 0;
  logic prevWr = 1'b0, prevOe = 1'b0, prevRx = 1'b0;

  usb_output #(
    .DEPTH          (DEPTH),
    .WR_CYCLES      (WR_CYC),
    .RECOVER_CYCLES (4)
  ) dut (
    .clock    (clock),
    .reset_b  (reset_b),
    .in       (in_byte),
    .newin    (newin),
    .hold     (hold),
    .rx_busy  (rx_busy),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .txe_b    (txe_b),
    .wr       (wr),
    .data_out (data_out),
    .data_oe  (data_oe)
`ifdef USB_OUTPUT_DEBUG_EN
    ,
    .state      (state),
    .sent_count (sent_count)
`endif
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycle++;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit expectDrop);
    in_byte = b;
    newin   = 1'b1;
    if (!expectDrop) expQ.push_back(b);
    @(posedge clock); #1;
    newin = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic waitWr(input string tag, input int limit);
    int n = 0;
    while (!wr && n < limit) begin
      @(posedge clock); #1;
      n++;
    end
    if (!wr) checkOutput(tag, 32'd0, 32'd1);
  endtask

  task automatic waitDrain(input int limit);
    int n = 0;
    while (expQ.size() != 0 && n < limit) begin
      @(posedge clock); #1;
      n++;
    end
    if (expQ.size() != 0) checkOutput("drain_timeout", expQ.size(), 32'd0);
    waitCycles(12);
  endtask

  // Bus monitor on the falling edge: pops the scoreboard when data_oe rises and checks the strobe shape.
  always @(negedge clock) begin
    if (!abortFlag) begin
      if (data_oe && !prevOe) begin
        oeRiseCycle = cycle;
        checkOutput("oe_while_rx_busy", {31'd0, prevRx}, 32'd0);
        if (expQ.size() == 0) checkOutput("unexpected_write", 32'd1, 32'd0);
        else curByte = expQ.pop_front();
      end
      if (data_oe) checkOutput("data_out", {24'd0, data_out}, {24'd0, curByte});
      if (wr && !prevWr) begin
        checkOutput("setup_len", cycle - oeRiseCycle, 32'd1);
        if (spacingOn && haveLastRise) checkOutput("byte_period", cycle - lastRise, BYTE_PERIOD);
        lastRise     = cycle;
        haveLastRise = 1'b1;
        wrRises++;
        wrHigh = 0;
      end
      if (wr) wrHigh++;
      if (!wr && prevWr) begin
        checkOutput("wr_width", wrHigh, WR_CYC);
        wrFallCycle = cycle;
      end
      if (!data_oe && prevOe) checkOutput("hold_len", cycle - wrFallCycle, 32'd1);
    end
    prevWr = wr;
    prevOe = data_oe;
    prevRx = rx_busy;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int lat;

    waitCycles(3);
    checkOutput("rst_wr", {31'd0, wr}, 32'd0);
    checkOutput("rst_data_oe", {31'd0, data_oe}, 32'd0);
    checkOutput("rst_data_out", {24'd0, data_out}, 32'd0);
    checkOutput("rst_full", {31'd0, full}, 32'd0);
    checkOutput("rst_empty", {31'd0, empty}, 32'd1);
    checkOutput("rst_overflow", {31'd0, overflow}, 32'd0);
    reset_b = 1'b1;
    waitCycles(1);

    $display("[TB] single byte 0xA5");
    txe_b = 1'b0;
    waitCycles(3);
    applyStimulus(8'hA5, 1'b0);
    waitDrain(40);
    checkOutput("t1_empty", {31'd0, empty}, 32'd1);
    checkOutput("t1_rises", wrRises, 32'd1);

    $display("[TB] fill to full with TXE# high, then drain");
    txe_b = 1'b1;
    waitCycles(3);
    for (int i = 1; i <= DEPTH; i++) applyStimulus(8'(i), 1'b0);
    checkOutput("t2_full", {31'd0, full}, 32'd1);
    checkOutput("t2_not_empty", {31'd0, empty}, 32'd0);
    checkOutput("t2_no_overflow_yet", {31'd0, overflow}, 32'd0);
    applyStimulus(8'hEE, 1'b1);
    checkOutput("t2_overflow", {31'd0, overflow}, 32'd1);
    checkOutput("t2_still_full", {31'd0, full}, 32'd1);
    base = wrRises;
    spacingOn = 1'b1;
    haveLastRise = 1'b0;
    txe_b = 1'b0;
    waitDrain(DEPTH * BYTE_PERIOD + 40);
    spacingOn = 1'b0;
    checkOutput("t2_sent", wrRises - base, DEPTH);
    checkOutput("t2_empty", {31'd0, empty}, 32'd1);
    checkOutput("t2_overflow_sticky", {31'd0, overflow}, 32'd1);

    $display("[TB] TXE# held high with 3 bytes queued");
    txe_b = 1'b1;
    waitCycles(3);
    base = wrRises;
    applyStimulus(8'h30, 1'b0);
    applyStimulus(8'h31, 1'b0);
    applyStimulus(8'h32, 1'b0);
    for (int i = 0; i < 10; i++) begin
      checkOutput("t3_no_wr", {31'd0, wr}, 32'd0);
      checkOutput("t3_no_oe", {31'd0, data_oe}, 32'd0);
      waitCycles(1);
    end
    txe_b = 1'b0;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      if (lat == 0) begin
        @(posedge clock); #1;
        if (wr) lat = i;
      end
    end
    checkOutput("t3_txe_latency", lat, 32'd4);
    waitDrain(60);
    checkOutput("t3_sent", wrRises - base, 32'd3);

    $display("[TB] rx_busy blocking and mid-write assertion");
    rx_busy = 1'b1;
    base = wrRises;
    applyStimulus(8'h40, 1'b0);
    applyStimulus(8'h41, 1'b0);
    applyStimulus(8'h42, 1'b0);
    for (int i = 0; i < 12; i++) begin
      checkOutput("t4_blocked_oe", {31'd0, data_oe}, 32'd0);
      waitCycles(1);
    end
    rx_busy = 1'b0;
    waitWr("t4_resume_timeout", 10);
    rx_busy = 1'b1;
    waitCycles(20);
    checkOutput("t4_one_completed", wrRises - base, 32'd1);
    rx_busy = 1'b0;
    waitDrain(60);
    checkOutput("t4_sent", wrRises - base, 32'd3);

    $display("[TB] reset during STROBE");
    applyStimulus(8'h50, 1'b0);
    applyStimulus(8'h51, 1'b0);
    waitWr("t5_strobe_timeout", 10);
    abortFlag = 1'b1;
    reset_b = 1'b0;
    #1;
    checkOutput("t5_wr_async", {31'd0, wr}, 32'd0);
    checkOutput("t5_oe_async", {31'd0, data_oe}, 32'd0);
    expQ.delete();
    waitCycles(1);
    checkOutput("t5_overflow_cleared", {31'd0, overflow}, 32'd0);
    checkOutput("t5_data_out_cleared", {24'd0, data_out}, 32'd0);
    reset_b = 1'b1;
    waitCycles(2);
    abortFlag = 1'b0;
    base = wrRises;
    waitCycles(20);
    checkOutput("t5_empty", {31'd0, empty}, 32'd1);
    checkOutput("t5_no_writes", wrRises - base, 32'd0);

`ifdef USB_OUTPUT_DEBUG_EN
    $display("[TB] debug counters after 5 bytes");
    for (int i = 0; i < 5; i++) applyStimulus(8'(8'h60 + i), 1'b0);
    waitDrain(80);
    checkOutput("dbg_sent_count", {16'd0, sent_count}, 32'd5);
    checkOutput("dbg_state", {28'd0, state}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
